// File: rtl/mem_access_unit_if.sv
// Data-memory port bundle: request/grant/response handshake between the
// load/store unit (master) and the data memory (slave).
interface mem_access_unit_if #(
   parameter int unsigned DMEM_AW = 12
) ();

   logic               mem_req;
   logic               mem_we;
   logic [DMEM_AW-1:0] mem_addr;
   logic [3:0]         mem_be;
   logic [31:0]        mem_wdata;
   logic               mem_gnt;
   logic               mem_rvalid;
   logic [31:0]        mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_gnt, mem_rvalid, mem_rdata
   );

endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a
// req/gnt/rvalid transaction, lane-aligns store data, extends load data and
// stalls the upstream pipeline until the access completes.
module mem_access_unit #(
   parameter int unsigned DMEM_AW = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_memread,
   input  logic              i_memwrite,
   input  logic [1:0]        i_length,
   input  logic              i_sign,
   input  logic [31:0]       i_addr,
   input  logic [31:0]       i_wdata,
   output logic [31:0]       o_rdata,
   output logic              o_stall,
   output logic              o_misalign,
   mem_access_unit_if.master bus
);

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StReq   = 2'd1,
      StWaitR = 2'd2
   } state_e;

   state_e             r_state;
   state_e             w_state_d;

   logic [DMEM_AW-1:0] r_addr;
   logic [3:0]         r_be;
   logic               r_we;
   logic [31:0]        r_wdata;
   logic [1:0]         r_len;
   logic               r_sign;
   logic [1:0]         r_off;
   logic [31:0]        r_rdata;

   logic               w_op;
   logic               w_aligned;
   logic               w_start;
   logic               w_done;
   logic               w_misalign;
   logic               w_load_done;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic [7:0]         w_byte;
   logic [15:0]        w_half;
   logic [31:0]        w_ext;
   logic               w_unused_addr;

   // Address bits above the memory window are don't-care.
   assign w_unused_addr = ^i_addr[31:DMEM_AW];

   assign w_op        = i_memread | i_memwrite;
   assign w_load_done = (r_state == StWaitR) & bus.mem_rvalid;

   // Alignment check on the incoming access size.
   always_comb begin
      w_aligned = 1'b1;
      unique case (i_length)
         2'b00:   w_aligned = 1'b1;
         2'b01:   w_aligned = ~i_addr[0];
         default: w_aligned = (i_addr[1:0] == 2'b00);
      endcase
   end

   // Byte-enable and lane replication for the incoming store.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_wdata;
      unique case (i_length)
         2'b00: begin
            w_be    = 4'b0001 << i_addr[1:0];
            w_wdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_wdata;
         end
      endcase
   end

   // Next-state logic; completion and misalignment are decided here.
   always_comb begin
      w_state_d  = r_state;
      w_start    = 1'b0;
      w_done     = 1'b0;
      w_misalign = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_op) begin
               if (w_aligned) begin
                  w_start   = 1'b1;
                  w_state_d = StReq;
               end else begin
                  w_misalign = 1'b1;
               end
            end
         end
         StReq: begin
            if (bus.mem_gnt) begin
               if (r_we) begin
                  w_done    = 1'b1;
                  w_state_d = StIdle;
               end else begin
                  w_state_d = StWaitR;
               end
            end
         end
         StWaitR: begin
            if (bus.mem_rvalid) begin
               w_done    = 1'b1;
               w_state_d = StIdle;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Request capture on access start and load-data holding register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_be    <= 4'b0000;
         r_we    <= 1'b0;
         r_wdata <= 32'h0;
         r_len   <= 2'b00;
         r_sign  <= 1'b0;
         r_off   <= 2'b00;
         r_rdata <= 32'h0;
      end else begin
         if (w_start) begin
            r_addr  <= {i_addr[DMEM_AW-1:2], 2'b00};
            r_be    <= w_be;
            r_we    <= i_memwrite;
            r_wdata <= w_wdata;
            r_len   <= i_length;
            r_sign  <= i_sign;
            r_off   <= i_addr[1:0];
         end
         if (w_load_done) begin
            r_rdata <= w_ext;
         end
      end
   end

   // Lane select and sign/zero extension of the returned read word.
   always_comb begin
      w_byte = bus.mem_rdata[7:0];
      unique case (r_off)
         2'd0: w_byte = bus.mem_rdata[7:0];
         2'd1: w_byte = bus.mem_rdata[15:8];
         2'd2: w_byte = bus.mem_rdata[23:16];
         2'd3: w_byte = bus.mem_rdata[31:24];
         default: w_byte = bus.mem_rdata[7:0];
      endcase
      w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      w_ext  = bus.mem_rdata;
      unique case (r_len)
         2'b00:   w_ext = {{24{r_sign & w_byte[7]}}, w_byte};
         2'b01:   w_ext = {{16{r_sign & w_half[15]}}, w_half};
         default: w_ext = bus.mem_rdata;
      endcase
   end

   assign bus.mem_req   = (r_state == StReq);
   assign bus.mem_we    = r_we;
   assign bus.mem_addr  = r_addr;
   assign bus.mem_be    = r_be;
   assign bus.mem_wdata = r_wdata;

   // Load data is forwarded combinationally in its completion cycle so MEM/WB
   // can capture it on the same edge the pipeline is released.
   assign o_rdata    = w_load_done ? w_ext : r_rdata;
   assign o_stall    = w_op & ~w_misalign & ~w_done;
   assign o_misalign = w_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// loads/stores against a transaction-level reference model.
module tb_mem_access_unit;

   localparam int unsigned DMEM_AW = 12;

   logic        clk = 1'b0;
   logic        rst;
   logic        memread;
   logic        memwrite;
   logic [1:0]  length;
   logic        sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        misalign;

   mem_access_unit_if #(.DMEM_AW(DMEM_AW)) bus ();

   mem_access_unit #(.DMEM_AW(DMEM_AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_memread  (memread),
      .i_memwrite (memwrite),
      .i_length   (length),
      .i_sign     (sign),
      .i_addr     (addr),
      .i_wdata    (wdata),
      .o_rdata    (rdata),
      .o_stall    (stall),
      .o_misalign (misalign),
      .bus        (bus.master)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_rdata;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic int f_size(input logic [1:0] len);
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] f_be(input logic [1:0] len, input logic [31:0] a);
      return 32'(((1 << f_size(len)) - 1) << (a % 4));
   endfunction

   function automatic logic [31:0] f_wdata(input logic [1:0] len, input logic [31:0] wd);
      if (f_size(len) == 1) return (wd & 32'hFF) * 32'h0101_0101;
      if (f_size(len) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] f_load(input logic [1:0] len, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] word);
      int     bits;
      longint v;
      if (f_size(len) == 4) return word;
      bits = 8 * f_size(len);
      v = (longint'(word) >> (8 * (a % 4))) & ((64'sd1 << bits) - 1);
      if (sgn && ((v >> (bits - 1)) & 1) == 1) v = v - (64'sd1 << bits);
      return 32'(v);
   endfunction

   // One complete access; gd = grant delay, rvd = extra rvalid delay after gnt.
   task automatic run_op(input string tag, input bit rd, input bit wr, input logic [1:0] len,
                         input bit sgn, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rvd, input logic [31:0] word);
      bit          st      = wr;
      bit          mis     = (a % f_size(len)) != 0;
      int          stall_n = 0;
      int          req_n   = 0;
      int          gnt_c   = -1;
      bit          done    = 0;
      bit          fin;
      logic [31:0] exp_ld;
      @(negedge clk);
      memread = rd; memwrite = wr; length = len; sign = sgn; addr = a; wdata = wd;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      #1;
      check_eq({tag, ".misalign"}, 32'(misalign), 32'(mis));
      if (mis) begin
         check_eq({tag, ".mis_stall"}, 32'(stall), 0);
         check_eq({tag, ".mis_req"}, 32'(bus.mem_req), 0);
         check_eq({tag, ".mis_rdata"}, rdata, model_rdata);
         @(negedge clk);
         memread = 1'b0; memwrite = 1'b0;
         #1;
         check_eq({tag, ".mis_req_next"}, 32'(bus.mem_req), 0);
         check_eq({tag, ".mis_pulse_end"}, 32'(misalign), 0);
         check_eq({tag, ".mis_rdata_next"}, rdata, model_rdata);
         return;
      end
      for (int c = 0; c < 64 && !done; c++) begin
         if (c > 0) begin
            @(negedge clk);
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
            #1;
         end
         fin = 0;
         if (bus.mem_req) begin
            check_eq({tag, ".addr"}, 32'(bus.mem_addr), a & 32'h0000_0FFC);
            check_eq({tag, ".be"}, 32'(bus.mem_be), f_be(len, a));
            check_eq({tag, ".we"}, 32'(bus.mem_we), 32'(st));
            if (st) check_eq({tag, ".wdata"}, bus.mem_wdata, f_wdata(len, wd));
            if (req_n == gd) begin
               bus.mem_gnt = 1'b1;
               gnt_c = c;
               fin = st;
            end
            req_n++;
         end else if (!st && gnt_c >= 0 && c == gnt_c + rvd + 1) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = word;
            fin = 1;
         end
         #1;
         if (stall) stall_n++;
         if (fin) begin
            check_eq({tag, ".stall_done"}, 32'(stall), 0);
            if (!st) begin
               exp_ld = f_load(len, sgn, a, word);
               check_eq({tag, ".rdata"}, rdata, exp_ld);
               model_rdata = exp_ld;
            end
            done = 1;
         end
      end
      check_eq({tag, ".completed"}, 32'(done), 1);
      check_eq({tag, ".stall_cycles"}, 32'(stall_n), 32'(st ? 1 + gd : 2 + gd + rvd));
      check_eq({tag, ".req_cycles"}, 32'(req_n), 32'(gd + 1));
   endtask

   task automatic idle_cycle(input bit stray);
      @(negedge clk);
      memread = 1'b0; memwrite = 1'b0; addr = $urandom;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = stray; bus.mem_rdata = $urandom;
      #1;
      check_eq("idle.stall", 32'(stall), 0);
      check_eq("idle.req", 32'(bus.mem_req), 0);
      check_eq("idle.rdata", rdata, model_rdata);
   endtask

   initial begin
      bit          r_rd;
      bit          r_wr;
      int          kind;
      logic [1:0]  r_len;
      logic [31:0] r_a;

      rst = 1'b1; memread = 1'b0; memwrite = 1'b0; length = 2'd0; sign = 1'b0;
      addr = 32'h0; wdata = 32'h0;
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
      model_rdata = 32'h0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst.rdata", rdata, 0);
      check_eq("rst.stall", 32'(stall), 0);
      check_eq("rst.misalign", 32'(misalign), 0);
      check_eq("rst.req", 32'(bus.mem_req), 0);
      check_eq("rst.we", 32'(bus.mem_we), 0);
      check_eq("rst.be", 32'(bus.mem_be), 0);
      check_eq("rst.addr", 32'(bus.mem_addr), 0);
      check_eq("rst.wdata", bus.mem_wdata, 0);
      rst = 1'b0;

      // Directed cases.
      run_op("sb", 0, 1, 2'd0, 0, 32'h0000_0103, 32'h0000_00AB, 0, 0, 32'h0);
      run_op("lh_s", 1, 0, 2'd1, 1, 32'h0000_0022, 32'h0, 0, 0, 32'h8001_1234);
      run_op("lh_u", 1, 0, 2'd1, 0, 32'h0000_0022, 32'h0, 0, 0, 32'h8001_1234);
      run_op("lbu", 1, 0, 2'd0, 0, 32'h0000_0041, 32'h0, 0, 0, 32'h0000_F000);
      run_op("lw_slow", 1, 0, 2'd2, 0, 32'h0000_0200, 32'h0, 2, 0, 32'hCAFE_F00D);
      run_op("lw_mis", 1, 0, 2'd2, 0, 32'h0000_0006, 32'h0, 0, 0, 32'h0);
      run_op("sh_hi", 0, 1, 2'd1, 0, 32'hFFFF_F7FE, 32'h1234_5678, 1, 0, 32'h0);
      run_op("both_st", 1, 1, 2'd3, 0, 32'h0000_0FFC, 32'h0BAD_BEEF, 0, 0, 32'h0);
      run_op("lb_s", 1, 0, 2'd0, 1, 32'h0000_0013, 32'h0, 0, 2, 32'h80FF_FFFF);
      idle_cycle(1);

      // Reset while waiting for read data abandons the access.
      @(negedge clk);
      memread = 1'b1; memwrite = 1'b0; length = 2'd2; sign = 1'b0; addr = 32'h80;
      #1;
      check_eq("rstw.stall_idle", 32'(stall), 1);
      @(negedge clk);
      bus.mem_gnt = 1'b1;
      #1;
      check_eq("rstw.req", 32'(bus.mem_req), 1);
      @(negedge clk);
      bus.mem_gnt = 1'b0; rst = 1'b1;
      #1;
      check_eq("rstw.wait_req", 32'(bus.mem_req), 0);
      @(negedge clk);
      rst = 1'b0; memread = 1'b0;
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      #1;
      model_rdata = 32'h0;
      check_eq("rstw.rdata", rdata, 0);
      check_eq("rstw.req_after", 32'(bus.mem_req), 0);
      check_eq("rstw.stall_after", 32'(stall), 0);
      check_eq("rstw.be", 32'(bus.mem_be), 0);
      idle_cycle(1);

      // Randomized accesses, mostly aligned, back-to-back with occasional gaps.
      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 2);
         r_rd = (kind != 1);
         r_wr = (kind != 0);
         r_len = 2'($urandom_range(0, 3));
         r_a = $urandom;
         if ($urandom_range(0, 3) != 0) r_a = r_a & ~32'(f_size(r_len) - 1);
         run_op("rnd", r_rd, r_wr, r_len, 1'($urandom_range(0, 1)), r_a, $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
         if ($urandom_range(0, 2) == 0) idle_cycle(1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
